// File: rtl/mtm_alu_pkg.sv
// rtl/mtm_alu_pkg.sv - shared opcodes, error bits, packet types, FSM states and CRC polynomial for the MTM ALU front end
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Bit positions inside err_flags = {ERR_DATA, ERR_CRC, ERR_OP}
  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  // x^4 + x + 1, x^4 term implicit
  localparam logic [3:0] CRC_POLY = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    TYPE,
    DATA,
    STOP
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// rtl/mtm_alu_crc4.sv - bit-serial CRC-4 (x^4+x+1), MSB-first, zero init
module mtm_alu_crc4
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [3:0] crc
);

  logic fb;
  assign fb = din ^ crc[3];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
    end
  end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// rtl/mtm_alu_deserializer.sv - serial packet front end of the MTM ALU; define MTM_ALU_CRC_CHECK_EN to enable CRC checking
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter int DATA_PKTS = 8,
  parameter int CRC_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  opmode,
  output logic        out_valid,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  localparam logic [3:0] CNT_FULL = 4'(DATA_PKTS);
  localparam logic [3:0] CNT_MAX  = 4'(DATA_PKTS + 1);

  state_t      state, state_nxt;
  logic        pkt_type;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  logic [7:0]  byte_sr;
  logic [63:0] data_sr;
  logic [2:0]  cmd_flags;
  logic        crc_ok;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!sin) state_nxt = TYPE;
      TYPE:    state_nxt = DATA;
      DATA:    if (bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MTM_ALU_CRC_CHECK_EN
  logic             crc_en;
  logic             crc_din;
  logic             crc_clr;
  logic [CRC_W-1:0] crc_val;

  // Command byte feeds {1'b1, op}: the transmitted pad bit is replaced by 1, CRC bits are skipped
  assign crc_en  = (state == DATA) && ((pkt_type == PKT_DATA) || (bit_cnt < 3'd4));
  assign crc_din = ((pkt_type == PKT_CMD) && (bit_cnt == 3'd0)) ? 1'b1 : sin;
  assign crc_clr = (state == STOP) && (!sin || (pkt_type == PKT_CMD));

  mtm_alu_crc4 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc_val)
  );

  assign crc_ok = (crc_val == byte_sr[CRC_W-1:0]);
`else
  assign crc_ok = 1'b1;
`endif

  // A wrong packet count masks the CRC and opcode checks
  always_comb begin
    cmd_flags = '0;
    if (byte_cnt != CNT_FULL) begin
      cmd_flags[ERR_DATA] = 1'b1;
    end else begin
      cmd_flags[ERR_CRC] = !crc_ok;
      cmd_flags[ERR_OP]  = !op_legal(byte_sr[6:4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_type  <= PKT_DATA;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      byte_sr   <= '0;
      data_sr   <= '0;
      A         <= '0;
      B         <= '0;
      opmode    <= '0;
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      err_flags <= '0;
    end else begin
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      case (state)
        TYPE: begin
          pkt_type <= sin;
          bit_cnt  <= '0;
        end
        DATA: begin
          byte_sr <= {byte_sr[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
        end
        STOP: begin
          if (!sin) begin
            err_valid           <= 1'b1;
            err_flags           <= '0;
            err_flags[ERR_DATA] <= 1'b1;
            byte_cnt            <= '0;
            data_sr             <= '0;
          end else if (pkt_type == PKT_DATA) begin
            data_sr <= {data_sr[55:0], byte_sr};
            if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 4'd1;
          end else begin
            byte_cnt <= '0;
            data_sr  <= '0;
            if (cmd_flags == 3'b000) begin
              B         <= data_sr[63:32];
              A         <= data_sr[31:0];
              opmode    <= byte_sr[6:4];
              out_valid <= 1'b1;
            end else begin
              err_flags <= cmd_flags;
              err_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb/tb_mtm_alu_deserializer.sv - table-driven and sequence checks of the MTM ALU deserializer
module tb_mtm_alu_deserializer;

  logic        clk;
  logic        rst;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  opmode;
  logic        out_valid;
  logic        err_valid;
  logic [2:0]  err_flags;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_a;
  logic [31:0] last_b;
  logic [2:0]  last_op;
  logic [2:0]  last_flags;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .A         (A),
    .B         (B),
    .opmode    (opmode),
    .out_valid (out_valid),
    .err_valid (err_valid),
    .err_flags (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          n_data;
    logic        use_model;
    logic [7:0]  cmd_lit;
    logic [3:0]  crc_xor;
    logic [2:0]  exp_crc;
    logic [2:0]  exp_nocrc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] crc_model(input logic [63:0] ba, input logic [2:0] op);
    logic [67:0] m;
    logic [3:0]  c;
    logic        fb;
    m = {ba, 1'b1, op};
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = m[i] ^ c[3];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic send_frame(input logic [63:0] ba, input int n, input logic [7:0] cmd);
    for (int i = 0; i < n; i++) begin
      if (i < 8) send_pkt(1'b0, ba[63-8*i -: 8], 1'b1);
      else       send_pkt(1'b0, 8'h55, 1'b1);
    end
    send_pkt(1'b1, cmd, 1'b1);
  endtask

  task automatic check_result(input string tag, input logic [2:0] exp,
                              input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (exp == 3'b000) begin
      chk({tag, "_pulse"}, {62'd0, out_valid, err_valid}, 64'b10);
      last_a  = a;
      last_b  = b;
      last_op = op;
    end else begin
      chk({tag, "_pulse"}, {62'd0, out_valid, err_valid}, 64'b01);
      last_flags = exp;
    end
    chk({tag, "_flags"}, {61'd0, err_flags}, {61'd0, last_flags});
    chk({tag, "_A"}, {32'd0, A}, {32'd0, last_a});
    chk({tag, "_B"}, {32'd0, B}, {32'd0, last_b});
    chk({tag, "_op"}, {61'd0, opmode}, {61'd0, last_op});
    send_bit(1'b1);
    chk({tag, "_pulse_end"}, {62'd0, out_valid, err_valid}, 64'b00);
  endtask

  task automatic good_frame(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    send_frame({b, a}, 8, {1'b0, op, crc_model({b, a}, op)});
    check_result(tag, 3'b000, a, b, op);
  endtask

  initial begin
    logic [7:0] cmd;
    logic [2:0] exp;

    vecs[0] = '{32'h0, 32'h0, 3'b000, 8, 1'b0, 8'h0B, 4'h0, 3'b000, 3'b000};
    vecs[1] = '{32'h0, 32'h0, 3'b000, 8, 1'b0, 8'h0A, 4'h0, 3'b010, 3'b000};
    vecs[2] = '{32'h0, 32'h0, 3'b010, 8, 1'b0, 8'h2D, 4'h0, 3'b001, 3'b001};
    vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 3'b100, 7, 1'b0, 8'h0B, 4'h0, 3'b100, 3'b100};
    vecs[4] = '{32'h12345678, 32'h9ABCDEF0, 3'b100, 8, 1'b1, 8'h00, 4'h0, 3'b000, 3'b000};
    vecs[5] = '{32'hDEADBEEF, 32'hCAFEF00D, 3'b101, 9, 1'b1, 8'h00, 4'h0, 3'b100, 3'b100};
    vecs[6] = '{32'hDEADBEEF, 32'hCAFEF00D, 3'b101, 8, 1'b1, 8'h00, 4'h0, 3'b000, 3'b000};
    vecs[7] = '{32'h01020304, 32'hA0B0C0D0, 3'b001, 8, 1'b1, 8'h00, 4'h1, 3'b010, 3'b000};
    vecs[8] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 3'b011, 8, 1'b1, 8'h00, 4'h2, 3'b011, 3'b001};
    vecs[9] = '{32'h00000001, 32'h80000000, 3'b000, 8, 1'b1, 8'h00, 4'h0, 3'b000, 3'b000};

    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_a = '0; last_b = '0; last_op = '0; last_flags = '0;

    chk("reset_A", {32'd0, A}, 64'd0);
    chk("reset_B", {32'd0, B}, 64'd0);
    chk("reset_op", {61'd0, opmode}, 64'd0);
    chk("reset_pulses", {62'd0, out_valid, err_valid}, 64'd0);
    chk("reset_flags", {61'd0, err_flags}, 64'd0);
    send_bit(1'b1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].use_model)
        cmd = {1'b0, vecs[i].op, crc_model({vecs[i].b, vecs[i].a}, vecs[i].op) ^ vecs[i].crc_xor};
      else
        cmd = vecs[i].cmd_lit;
`ifdef MTM_ALU_CRC_CHECK_EN
      exp = vecs[i].exp_crc;
`else
      exp = vecs[i].exp_nocrc;
`endif
      send_frame({vecs[i].b, vecs[i].a}, vecs[i].n_data, cmd);
      check_result($sformatf("v%0d", i), exp, vecs[i].a, vecs[i].b, vecs[i].op);
    end

    // Framing error on the fourth data packet, then a clean frame
    send_pkt(1'b0, 8'h11, 1'b1);
    send_pkt(1'b0, 8'h22, 1'b1);
    send_pkt(1'b0, 8'h33, 1'b1);
    send_pkt(1'b0, 8'h44, 1'b0);
    check_result("frame_err", 3'b100, 32'd0, 32'd0, 3'd0);
    good_frame("after_frame_err", 32'h55AA33CC, 32'h01234567, 3'b101);

    // Back-to-back: the next start bit directly follows a stop bit
    send_frame({32'h89ABCDEF, 32'h76543210}, 8, {1'b0, 3'b001, crc_model({32'h89ABCDEF, 32'h76543210}, 3'b001)});
    check_result("b2b", 3'b000, 32'h76543210, 32'h89ABCDEF, 3'b001);

    // Reset in the middle of the third packet's data bits
    send_pkt(1'b0, 8'hFE, 1'b1);
    send_pkt(1'b0, 8'hDC, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    sin = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_a = '0; last_b = '0; last_op = '0; last_flags = '0;
    chk("midrst_A", {32'd0, A}, 64'd0);
    chk("midrst_B", {32'd0, B}, 64'd0);
    chk("midrst_op", {61'd0, opmode}, 64'd0);
    chk("midrst_flags", {61'd0, err_flags}, 64'd0);
    chk("midrst_pulses", {62'd0, out_valid, err_valid}, 64'd0);
    send_bit(1'b1);
    good_frame("after_rst", 32'hCAFEBABE, 32'h0BADF00D, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
